// File: rtl/clock_div_monitor_pkg.sv
// Shared types and helpers for the divided-clock monitor.
package clock_div_monitor_pkg;

  typedef enum logic [1:0] {
    ACQUIRE = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_e;

  // Largest value a counter of the given width can hold; counters stick here.
  function automatic int unsigned sat_count(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/clock_div_monitor_if.sv
// Divided-clock input, sticky-flag clear and measurement outputs of the monitor.
interface clock_div_monitor_if #(
  parameter int CNT_WIDTH = 8
);
  logic                 div_clk;
  logic                 clear;
  logic                 meas_valid;
  logic [CNT_WIDTH-1:0] meas_period;
  logic [CNT_WIDTH-1:0] meas_high;
  logic                 locked;
  logic                 err_mismatch;
  logic                 err_timeout;

  // Harness side: drives the divided clock and clear, observes results.
  modport master (
    output div_clk, clear,
    input  meas_valid, meas_period, meas_high, locked, err_mismatch, err_timeout
  );

  // Monitor side.
  modport slave (
    input  div_clk, clear,
    output meas_valid, meas_period, meas_high, locked, err_mismatch, err_timeout
  );
endinterface

// File: rtl/clock_div_monitor_sync.sv
// Optional input register chain for the sampled divided clock.
// With zero stages the input passes straight through (phase-aligned dividers).
module clock_sample_sync #(
  parameter int SYNC_STAGES = 0
) (
  input  logic clock,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  if (SYNC_STAGES == 0) begin : g_bypass
    logic unused_clk_rst;
    assign unused_clk_rst = clock | reset;
    assign q_o = d_i;
  end else begin : g_chain
    logic [SYNC_STAGES-1:0] sync_q;

    // Shift the sample through the chain; oldest stage feeds the output.
    always_ff @(posedge clock) begin
      if (reset) begin
        sync_q <= '0;
      end else begin
        sync_q[0] <= d_i;
        for (int i = 1; i < SYNC_STAGES; i++) begin
          sync_q[i] <= sync_q[i-1];
        end
      end
    end

    assign q_o = sync_q[SYNC_STAGES-1];
  end

endmodule

// File: rtl/clock_div_monitor.sv
// Measures period and high time of a divided clock sampled as data, and
// declares lock after LOCK_COUNT consecutive periods match expectation.
//
// state   | meaning
// ACQUIRE | waiting for the first rising edge; no measurement yet
// MEASURE | measuring, counting consecutive matching periods
// LOCKED  | waveform matches; any bad period drops lock and flags mismatch
module clock_div_monitor
  import clock_div_monitor_pkg::*;
#(
  parameter int CNT_WIDTH     = 8,
  parameter int EXPECT_PERIOD = 3,
  parameter int EXPECT_HIGH   = 2,
  parameter int LOCK_COUNT    = 4,
  parameter int SYNC_STAGES   = 0
) (
  input  logic               clock,
  input  logic               reset,
  clock_div_monitor_if.slave mon
);

  localparam logic [CNT_WIDTH-1:0] CNT_SAT = CNT_WIDTH'(sat_count(CNT_WIDTH));
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] EXP_PER = CNT_WIDTH'(EXPECT_PERIOD);
  localparam logic [CNT_WIDTH-1:0] EXP_HI  = CNT_WIDTH'(EXPECT_HIGH);
  localparam logic [3:0]           LOCK_N  = 4'(LOCK_COUNT);

  logic                 s;
  logic                 s_d_q;
  logic                 rise;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] hi_q, hi_d;
  logic                 match;
  logic                 lock_hit;
  logic                 timeout;

  state_e               state_q;
  logic [3:0]           mc_q;
  logic                 meas_valid_q;
  logic [CNT_WIDTH-1:0] meas_period_q;
  logic [CNT_WIDTH-1:0] meas_high_q;
  logic                 locked_q;
  logic                 err_mismatch_q;
  logic                 err_timeout_q;

  clock_sample_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clock (clock),
    .reset (reset),
    .d_i   (mon.div_clk),
    .q_o   (s)
  );

  assign rise     = s & ~s_d_q;
  assign match    = (cnt_q == EXP_PER) && (hi_q == EXP_HI);
  assign lock_hit = (mc_q + 4'd1) == LOCK_N;
  // A rise landing on saturation is an edge, never a timeout.
  assign timeout  = (cnt_q == CNT_SAT) && !rise;

  // Next values of the saturating period and high-time counters.
  always_comb begin
    cnt_d = cnt_q;
    hi_d  = hi_q;
    if (rise) begin
      cnt_d = CNT_ONE;
      hi_d  = CNT_ONE;
    end else begin
      if (cnt_q != CNT_SAT) cnt_d = cnt_q + CNT_ONE;
      if (s && (hi_q != CNT_SAT)) hi_d = hi_q + CNT_ONE;
    end
  end

  // Edge-detect history and counter registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      s_d_q <= 1'b0;
      cnt_q <= '0;
      hi_q  <= '0;
    end else begin
      s_d_q <= s;
      cnt_q <= cnt_d;
      hi_q  <= hi_d;
    end
  end

  // Lock FSM with registered measurement outputs and sticky flags.
  // Flag sets are written after the clear so a same-cycle set wins.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= ACQUIRE;
      mc_q           <= '0;
      meas_valid_q   <= 1'b0;
      meas_period_q  <= '0;
      meas_high_q    <= '0;
      locked_q       <= 1'b0;
      err_mismatch_q <= 1'b0;
      err_timeout_q  <= 1'b0;
    end else begin
      meas_valid_q <= 1'b0;
      if (mon.clear) begin
        err_mismatch_q <= 1'b0;
        err_timeout_q  <= 1'b0;
      end
      case (state_q)
        ACQUIRE: begin
          if (rise) begin
            state_q <= MEASURE;
            mc_q    <= '0;
          end
        end
        MEASURE: begin
          if (rise) begin
            meas_valid_q  <= 1'b1;
            meas_period_q <= cnt_q;
            meas_high_q   <= hi_q;
            if (match) begin
              mc_q <= mc_q + 4'd1;
              if (lock_hit) begin
                state_q  <= LOCKED;
                locked_q <= 1'b1;
              end
            end else begin
              mc_q <= '0;
            end
          end else if (timeout) begin
            state_q       <= ACQUIRE;
            mc_q          <= '0;
            err_timeout_q <= 1'b1;
          end
        end
        LOCKED: begin
          if (rise) begin
            meas_valid_q  <= 1'b1;
            meas_period_q <= cnt_q;
            meas_high_q   <= hi_q;
            if (!match) begin
              state_q        <= MEASURE;
              mc_q           <= '0;
              locked_q       <= 1'b0;
              err_mismatch_q <= 1'b1;
            end
          end else if (timeout) begin
            state_q       <= ACQUIRE;
            mc_q          <= '0;
            locked_q      <= 1'b0;
            err_timeout_q <= 1'b1;
          end
        end
        default: begin
          state_q  <= ACQUIRE;
          mc_q     <= '0;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

  assign mon.meas_valid   = meas_valid_q;
  assign mon.meas_period  = meas_period_q;
  assign mon.meas_high    = meas_high_q;
  assign mon.locked       = locked_q;
  assign mon.err_mismatch = err_mismatch_q;
  assign mon.err_timeout  = err_timeout_q;

endmodule

// File: doc/clock_div_monitor.md
# clock_div_monitor

Receive-side checker for divided clocks produced by the clock-divider black boxes. It samples a divided clock as data in the source clock domain, detects its rising edges, and measures period and high time in source-clock cycles. It asserts lock once the measured waveform has matched the expected ratio and duty for a programmable number of consecutive periods. It sits beside each divider instance in simulation and test harnesses and provides per-period measurements plus sticky mismatch and timeout flags.

## Interface
- CNT_WIDTH, 8: width of the period and high-time counters and outputs.
- EXPECT_PERIOD, 3: expected period in `clock` cycles.
- EXPECT_HIGH, 2: expected high time in `clock` cycles.
- LOCK_COUNT, 4: consecutive matching periods required for lock (1..15).
- SYNC_STAGES, 0: input register stages (0..3); 0 for phase-aligned dividers.

Ports:
- clock  input  1  sole clock; all state is updated on its rising edge.
- reset  input  1  synchronous, active-high reset.
- div_clk  input  1  divided clock, sampled as data.
- clear  input  1  clears sticky error flags.
- meas_valid  output  1  one-cycle pulse when a complete period is measured.
- meas_period  output  CNT_WIDTH  last measured period; holds between pulses.
- meas_high  output  CNT_WIDTH  last measured high time; holds between pulses.
- locked  output  1  waveform matches expectation.
- err_mismatch  output  1  sticky; a measurement mismatched while locked.
- err_timeout  output  1  sticky; no rising edge for 2^CNT_WIDTH-1 cycles.

## Operation
- s is div_clk after SYNC_STAGES flops. s_d is s delayed one cycle. rise = s & ~s_d.
- Period counter cnt:
  - On rise: cnt <= 1.
  - Otherwise: cnt <= cnt+1, saturating at 2^CNT_WIDTH-1.
- High counter hi:
  - On rise: hi <= 1.
  - Else if s: hi <= hi+1 (saturating).
  - Else: hold.
- States: ACQUIRE, MEASURE, LOCKED. Match counter mc is 4 bits.
- ACQUIRE: the first rise moves to MEASURE. No meas_valid on that rise.
- MEASURE/LOCKED, on rise:
  - meas_valid=1, meas_period<=cnt, meas_high<=hi.
  - match = (cnt==EXPECT_PERIOD && hi==EXPECT_HIGH).
- MEASURE transitions:
  - match: mc<=mc+1. When mc+1==LOCK_COUNT, go to LOCKED.
  - No match: mc<=0.
- LOCKED transitions:
  - match: stay.
  - No match: go to MEASURE, mc<=0, err_mismatch<=1.
- Timeout: in MEASURE or LOCKED, when cnt==2^CNT_WIDTH-1 and there is no rise:
  - go to ACQUIRE, err_timeout<=1, mc<=0.
  - ACQUIRE itself never times out.
- locked = (state==LOCKED), registered.
- clear deasserts both sticky flags. If a new error is set in the same cycle, the set wins.
- Reset values:
  - All outputs, counters, sync flops, s_d and mc are 0.
  - State is ACQUIRE.
  - Reset asserted mid-period discards the partial measurement.

## Timing
- Edge-detect latency from a div_clk rise to the rise cycle is SYNC_STAGES cycles.
- meas_valid, meas_period and meas_high are registered and appear one cycle after the rise cycle.
- locked rises in the same cycle as the meas_valid of the LOCK_COUNT-th consecutive match.
- locked falls in the same cycle as the mismatching meas_valid. err_mismatch sets in that same cycle.
- err_timeout sets, and locked falls, one cycle after cnt reaches saturation.
- Divide-by-3, 2:1 pattern (s = 1,1,0 repeating): one meas_valid every 3 cycles with period 3, high 2.
- A rise coinciding with saturation counts as an edge, not a timeout.

## Structure
- Package clock_div_monitor_pkg:
  - state enum (ACQUIRE/MEASURE/LOCKED)
  - saturating-count constant function of CNT_WIDTH
- Sub-module clock_sample_sync: parameterised SYNC_STAGES flop chain, reset to 0, pass-through when the parameter is 0.
- The main block holds the edge detect, both counters, the FSM and the flags.

## Test plan
- Drive s = 110 repeated, defaults:
  - meas_valid every 3 cycles with period=3, high=2.
  - locked=1 at the 4th meas_valid.
  - No error flags.
- While locked, stretch one low phase to 2 cycles (1100):
  - that meas_valid reports period=4, high=2.
  - locked=0 and err_mismatch=1 in the same cycle.
  - Relocks after 4 further good periods. err_mismatch stays 1 until clear.
- Drive a 100 pattern (period 3, high 1): reports high=1 each period, locked never asserts, no errors.
- Hold div_clk low after lock:
  - err_timeout=1 and locked=0 after cnt saturates at 255.
  - The next rise produces no meas_valid. The second rise does.
- Pulse clear in the same cycle a mismatch is flagged: err_mismatch remains 1. A clear on the following cycle deasserts it.
- Assert reset for one cycle mid-period while locked: all outputs return to 0 and state is ACQUIRE. The first valid comes on the second post-reset rise.
